// File: rtl/interleaved_bank_array.sv
// Address-interleaved banked operand store: one byte-writable write port and
// NUM_RD_PORTS read ports arbitrated round-robin per bank, with same-address broadcast.
module interleaved_bank_array #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 64,
  parameter int BANK_COUNT   = 4,
  parameter int NUM_RD_PORTS = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [DATA_WIDTH/8-1:0]          wr_be,
  input  logic [NUM_RD_PORTS-1:0]          rd_req_valid,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_req_addr,
  output logic [NUM_RD_PORTS-1:0]          rd_req_ready,
  output logic [NUM_RD_PORTS-1:0]          rd_resp_valid,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_resp_data,
  output logic [CNT_WIDTH-1:0]             conflict_count
);

  localparam int BANK_BITS = $clog2(BANK_COUNT);
  localparam int ROW_BITS  = ADDR_WIDTH - BANK_BITS;
  localparam int ROWS      = 1 << ROW_BITS;
  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int PTR_W     = (NUM_RD_PORTS > 1) ? $clog2(NUM_RD_PORTS) : 1;
  localparam int DEN_W     = $clog2(NUM_RD_PORTS + 1);
  localparam int SUM_W     = CNT_WIDTH + DEN_W;

  // Words are stored XORed with their own global address, so an all-zero
  // array reads back as "word a holds a" without any per-word initial values.
  logic [DATA_WIDTH-1:0] mem [BANK_COUNT][ROWS] = '{default: '0};

  logic [ADDR_WIDTH-1:0] port_addr  [NUM_RD_PORTS];
  logic [BANK_BITS-1:0]  port_bank  [NUM_RD_PORTS];
  logic [ROW_BITS-1:0]   port_row   [NUM_RD_PORTS];
  logic [DATA_WIDTH-1:0] port_rdata [NUM_RD_PORTS];

  logic [PTR_W-1:0]      rr_ptr        [BANK_COUNT];
  logic                  bank_found    [BANK_COUNT];
  logic [PTR_W-1:0]      bank_win      [BANK_COUNT];
  logic [ADDR_WIDTH-1:0] bank_win_addr [BANK_COUNT];
  int                    best_dist     [BANK_COUNT];

  logic [NUM_RD_PORTS-1:0] grant;
  logic [DEN_W-1:0]        denied;
  logic [SUM_W-1:0]        cnt_sum;

  logic [BANK_BITS-1:0]  wr_bank;
  logic [ROW_BITS-1:0]   wr_row;
  logic [DATA_WIDTH-1:0] wr_key;

  function automatic int ring_dist(input int port, input int ptr);
    return (port >= ptr) ? (port - ptr) : (port + NUM_RD_PORTS - ptr);
  endfunction

  always_comb begin
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      port_addr[p]  = rd_req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      port_bank[p]  = port_addr[p][BANK_BITS-1:0];
      port_row[p]   = port_addr[p][ADDR_WIDTH-1:BANK_BITS];
      port_rdata[p] = mem[port_bank[p]][port_row[p]] ^ DATA_WIDTH'(port_addr[p]);
    end
  end

  // The winner in each bank is the requester closest to rr_ptr going upward.
  always_comb begin
    for (int b = 0; b < BANK_COUNT; b++) begin
      bank_found[b]    = 1'b0;
      bank_win[b]      = '0;
      bank_win_addr[b] = '0;
      best_dist[b]     = NUM_RD_PORTS;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (rd_req_valid[p] && (port_bank[p] == BANK_BITS'(b)) &&
            (ring_dist(p, int'(rr_ptr[b])) < best_dist[b])) begin
          bank_found[b]    = 1'b1;
          bank_win[b]      = PTR_W'(p);
          bank_win_addr[b] = port_addr[p];
          best_dist[b]     = ring_dist(p, int'(rr_ptr[b]));
        end
      end
    end
  end

  always_comb begin
    grant  = '0;
    denied = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      grant[p] = !rst && !stall && rd_req_valid[p] && bank_found[port_bank[p]] &&
                 (port_addr[p] == bank_win_addr[port_bank[p]]);
      if (rd_req_valid[p] && !grant[p]) begin
        denied = denied + DEN_W'(1);
      end
    end
    cnt_sum = SUM_W'(conflict_count) + SUM_W'(denied);
  end

  assign rd_req_ready = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < BANK_COUNT; b++) begin
        rr_ptr[b] <= '0;
      end
    end else if (!stall) begin
      for (int b = 0; b < BANK_COUNT; b++) begin
        if (bank_found[b]) begin
          rr_ptr[b] <= (bank_win[b] == PTR_W'(NUM_RD_PORTS - 1)) ? '0 : bank_win[b] + PTR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_count <= '0;
    end else if (!stall) begin
      conflict_count <= (cnt_sum > SUM_W'({CNT_WIDTH{1'b1}})) ? {CNT_WIDTH{1'b1}}
                                                              : cnt_sum[CNT_WIDTH-1:0];
    end
  end

  // Ungranted ports keep their last data; only the valid bit drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_resp_valid <= '0;
      rd_resp_data  <= '0;
    end else if (!stall) begin
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        rd_resp_valid[p] <= grant[p];
        if (grant[p]) begin
          rd_resp_data[p*DATA_WIDTH +: DATA_WIDTH] <= port_rdata[p];
        end
      end
    end
  end

  assign wr_bank = wr_addr[BANK_BITS-1:0];
  assign wr_row  = wr_addr[ADDR_WIDTH-1:BANK_BITS];
  assign wr_key  = DATA_WIDTH'(wr_addr);

  // Writes ignore both stall and rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int j = 0; j < BYTES; j++) begin
        if (wr_be[j]) begin
          mem[wr_bank][wr_row][8*j +: 8] <= wr_data[8*j +: 8] ^ wr_key[8*j +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_interleaved_bank_array.sv
// Directed plus randomized bench for interleaved_bank_array against a
// behavioural memory/arbiter model; a second instance exercises counter saturation.
module tb_interleaved_bank_array;

  localparam int AW = 8;
  localparam int DW = 64;
  localparam int BC = 4;
  localparam int NP = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [DW/8-1:0]  wr_be;
  logic [NP-1:0]    rd_req_valid;
  logic [NP*AW-1:0] rd_req_addr;

  logic [NP-1:0]    rd_req_ready, ready_sat;
  logic [NP-1:0]    rd_resp_valid, resp_valid_sat;
  logic [NP*DW-1:0] rd_resp_data, resp_data_sat;
  logic [31:0]      conflict_count;
  logic [1:0]       count_sat;

  always #5 clk = ~clk;

  interleaved_bank_array dut (
    .clk(clk), .rst(rst), .stall(stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .conflict_count(conflict_count)
  );

  interleaved_bank_array #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(ready_sat),
    .rd_resp_valid(resp_valid_sat), .rd_resp_data(resp_data_sat),
    .conflict_count(count_sat)
  );

  // Reference model state
  logic [DW-1:0] mem_m [256];
  int            ptr_m [BC];
  int            win_m [BC];
  int            vld_m [NP];
  int            adr_m [NP];
  logic [NP-1:0] exp_ready;
  logic [NP-1:0] exp_valid;
  logic [DW-1:0] exp_data [NP];
  longint        cnt_m;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic s, input logic we,
                                input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic [7:0] wbe, input logic [NP-1:0] v,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rst          = r;
    stall        = s;
    wr_en        = we;
    wr_addr      = wa;
    wr_data      = wd;
    wr_be        = wbe;
    rd_req_valid = v;
    rd_req_addr  = {a1, a0};
  endtask

  // Arbitration rules: first requester cyclically from the pointer wins,
  // same-address requesters in the bank share the grant.
  task automatic model_ready();
    for (int p = 0; p < NP; p++) begin
      vld_m[p] = int'(rd_req_valid[p]);
      adr_m[p] = int'(rd_req_addr[p*AW +: AW]);
    end
    exp_ready = '0;
    for (int b = 0; b < BC; b++) begin
      win_m[b] = -1;
      if (!rst && !stall) begin
        for (int k = 0; k < NP; k++) begin
          int q;
          q = (ptr_m[b] + k) % NP;
          if (win_m[b] < 0 && vld_m[q] != 0 && (adr_m[q] % BC) == b) win_m[b] = q;
        end
        if (win_m[b] >= 0) begin
          for (int p = 0; p < NP; p++) begin
            if (vld_m[p] != 0 && adr_m[p] == adr_m[win_m[b]]) exp_ready[p] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic model_update();
    if (rst) begin
      exp_valid = '0;
      for (int p = 0; p < NP; p++) exp_data[p] = '0;
      for (int b = 0; b < BC; b++) ptr_m[b] = 0;
      cnt_m = 0;
    end else if (!stall) begin
      for (int p = 0; p < NP; p++) begin
        exp_valid[p] = exp_ready[p];
        if (exp_ready[p]) exp_data[p] = mem_m[adr_m[p]];
        if (vld_m[p] != 0 && !exp_ready[p]) cnt_m++;
      end
      for (int b = 0; b < BC; b++) begin
        if (win_m[b] >= 0) ptr_m[b] = (win_m[b] + 1) % NP;
      end
    end
    if (wr_en) begin
      for (int j = 0; j < DW/8; j++) begin
        if (wr_be[j]) mem_m[wr_addr][8*j +: 8] = wr_data[8*j +: 8];
      end
    end
  endtask

  task automatic check_output();
    longint c32, c2;
    c32 = (cnt_m > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : cnt_m;
    c2  = (cnt_m > 3) ? 3 : cnt_m;
    check_val("resp_valid", 64'(rd_resp_valid), 64'(exp_valid));
    for (int p = 0; p < NP; p++) begin
      check_val($sformatf("resp_data_p%0d", p), rd_resp_data[p*DW +: DW], exp_data[p]);
    end
    check_val("conflict_count", 64'(conflict_count), 64'(c32));
    check_val("sat_resp_valid", 64'(resp_valid_sat), 64'(exp_valid));
    check_val("sat_conflict_count", 64'(count_sat), 64'(c2));
  endtask

  // One clock: ready checked mid-cycle, registered outputs just after the edge.
  task automatic step();
    @(negedge clk);
    model_ready();
    check_val("rd_req_ready", 64'(rd_req_ready), 64'(exp_ready));
    check_val("sat_rd_req_ready", 64'(ready_sat), 64'(exp_ready));
    @(posedge clk);
    model_update();
    #1;
    check_output();
  endtask

  initial begin
    logic [NP-1:0] v;
    logic [AW-1:0] a [NP];

    for (int i = 0; i < 256; i++) mem_m[i] = DW'(i);
    for (int b = 0; b < BC; b++) ptr_m[b] = 0;
    exp_valid = '0;
    exp_ready = '0;
    for (int p = 0; p < NP; p++) exp_data[p] = '0;
    cnt_m = 0;

    $display("[TB] reset");
    apply_stimulus(1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    step();
    step();

    $display("[TB] parallel reads");
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'b11, 8'd5, 8'd6);
    step();
    check_val("init_p0_is_5", rd_resp_data[63:0], 64'd5);
    check_val("init_p1_is_6", rd_resp_data[127:64], 64'd6);

    $display("[TB] bank conflict round-robin");
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'b11, 8'd4, 8'd8);
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("rr_valid", 64'(rd_resp_valid), (i % 2 == 0) ? 64'b01 : 64'b10);
    end
    check_val("rr_count_is_4", 64'(conflict_count), 64'd4);

    $display("[TB] broadcast");
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'b11, 8'd12, 8'd12);
    step();
    check_val("bcast_p0", rd_resp_data[63:0], 64'd12);
    check_val("bcast_p1", rd_resp_data[127:64], 64'd12);
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'b11, 8'd0, 8'd4);
    step();
    check_val("bcast_ptr_p1_next", 64'(rd_resp_valid), 64'b10);

    $display("[TB] byte-enable write, read-first");
    apply_stimulus(0, 0, 1, 8'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 2'b01, 8'd3, 8'd0);
    step();
    check_val("read_first_old", rd_resp_data[63:0], 64'd3);
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'b01, 8'd3, 8'd0);
    step();
    check_val("byte_enable_new", rd_resp_data[63:0], 64'h0000_0000_FFFF_FFFF);

    $display("[TB] stall hold");
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'b01, 8'd7, 8'd0);
    step();
    apply_stimulus(0, 1, 0, 0, 0, 0, 2'b01, 8'd9, 8'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("stall_hold_data", rd_resp_data[63:0], 64'd7);
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'b01, 8'd9, 8'd0);
    step();
    check_val("stall_release", rd_resp_data[63:0], 64'd9);

    $display("[TB] reset mid-flight");
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'b01, 8'd10, 8'd0);
    step();
    apply_stimulus(1, 0, 1, 8'd20, 64'hABCD, 8'hFF, 2'b01, 8'd10, 8'd0);
    step();
    check_val("rst_valid_zero", 64'(rd_resp_valid), 64'd0);
    check_val("rst_data_zero", rd_resp_data[63:0], 64'd0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'b01, 8'd20, 8'd0);
    step();
    check_val("write_during_rst", rd_resp_data[63:0], 64'hABCD);

    $display("[TB] saturation");
    apply_stimulus(0, 0, 0, 0, 0, 0, 2'b11, 8'd1, 8'd5);
    for (int i = 0; i < 5; i++) step();
    check_val("sat_count_is_3", 64'(count_sat), 64'd3);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NP; p++) begin
        if (rd_req_valid[p] && !exp_ready[p] && !rst) begin
          v[p] = 1'b1;
          a[p] = rd_req_addr[p*AW +: AW];
        end else begin
          v[p] = ($urandom_range(0, 3) != 0);
          a[p] = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
        end
      end
      apply_stimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 15)),
                     {$urandom, $urandom}, 8'($urandom), v, a[0], a[1]);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interleaved_bank_array.md
# interleaved_bank_array

Multi-port, address-interleaved banked memory: next generation of the single `bank` primitive. It instantiates `BANK_COUNT` byte-writable banks behind a global word address, serves `NUM_RD_PORTS` independent read ports through a per-bank round-robin arbiter, and broadcasts identical-address reads. It is the operand store feeding the vector lanes: one shared write port from writeback, read ports to the lane front-ends, and a pipeline-wide `stall` input.

## Interface
- `ADDR_WIDTH`, 8: global word address width. Bank = `addr[BANK_BITS-1:0]`, bank-local row = `addr[ADDR_WIDTH-1:BANK_BITS]`.
- `DATA_WIDTH`, 64: word width; multiple of 8.
- `BANK_COUNT`, 4: number of banks; power of two, ≥2. `BANK_BITS` = log2(`BANK_COUNT`).
- `NUM_RD_PORTS`, 2: number of read ports, ≥1.
- `CNT_WIDTH`, 32: width of the conflict counter.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`  in  1  freezes the read path.
- `wr_en`  in  1  write enable.
- `wr_addr`  in  `ADDR_WIDTH`  global write word address.
- `wr_data`  in  `DATA_WIDTH`  write data.
- `wr_be`  in  `DATA_WIDTH/8`  byte enables; bit j covers `wr_data[8j+7:8j]`.
- `rd_req_valid`  in  `NUM_RD_PORTS`  per-port read request.
- `rd_req_addr`  in  `NUM_RD_PORTS*ADDR_WIDTH`  port p's address in slice p.
- `rd_req_ready`  out  `NUM_RD_PORTS`  per-port grant; combinational.
- `rd_resp_valid`  out  `NUM_RD_PORTS`  response valid.
- `rd_resp_data`  out  `NUM_RD_PORTS*DATA_WIDTH`  response data, slice p.
- `conflict_count`  out  `CNT_WIDTH`  saturating count of denied requests.

## Operation
- Initial contents: the word at global address a holds a, zero-extended to `DATA_WIDTH`. No reset of array contents.
- Writes:
  - Performed every cycle `wr_en`=1, regardless of `stall` and `rst`.
  - Only bytes with `wr_be[j]`=1 are updated.
  - The write goes to bank `wr_addr % BANK_COUNT`.
- Arbitration, per bank b, each cycle `stall`=0:
  - Requesters are the ports with valid=1 whose address maps to bank b.
  - Winner is the first requester at or after `rr_ptr[b]`, searching cyclically up by port index.
  - Every requester whose full address equals the winner's address is also granted (broadcast).
  - All other requesters to bank b get ready=0 and must hold valid and address.
- Pointer update: on any grant in bank b, `rr_ptr[b]` ← (winner+1) mod `NUM_RD_PORTS`. Broadcast co-grantees do not affect the pointer. With no grant, the pointer is unchanged.
- A port with valid=0 has ready=0.
- Stall:
  - All `rd_req_ready`=0.
  - `rd_resp_valid` and `rd_resp_data` hold their values.
  - Pointers and counter are frozen.
- `conflict_count` adds the number of ports with valid=1 & ready=0 & `stall`=0 each cycle, and saturates at all-ones.
- Reset: `rd_resp_valid`=0, `rd_resp_data`=0, `conflict_count`=0, all `rr_ptr`=0. `rd_req_ready` is forced to 0 while `rst`=1.

## Timing
- Accepted read (valid & ready at edge N) → `rd_resp_valid[p]`=1 and data after edge N, i.e. visible in cycle N+1. One-cycle latency.
- A port not accepted at edge N (`stall`=0) shows `rd_resp_valid[p]`=0 in cycle N+1.
- Back-to-back accepts on one port: one response per cycle, full throughput.
- Read and write to the same address in the same cycle: read-first. The read returns the pre-write data; the new data is visible from the next read.
- `stall` asserted in cycle N: outputs in N+1 equal those in N. Deasserting `stall` resumes arbitration in that same cycle.
- `rst` mid-operation: in-flight responses are discarded, and outputs are 0 in the cycle after the reset edge. Writes presented during reset still commit.

## Test plan
Configuration for all scenarios: defaults (`BANK_COUNT`=4, `NUM_RD_PORTS`=2).
- **Init and parallel reads.** After reset, port0 reads addr 5 and port1 reads addr 6 in the same cycle. Both ready=1; next cycle port0 data = 5, port1 data = 6; `conflict_count`=0.
- **Bank conflict and round-robin.** Both ports hold valid with port0 at addr 4 and port1 at addr 8 (both bank 0) for 4 cycles.
  - Grants alternate p0, p1, p0, p1.
  - Responses return 4, 8, 4, 8.
  - `conflict_count`=4.
- **Broadcast.** Both ports read addr 12 in the same cycle. Both ready=1; both responses = 12; the pointer advances past the winner only.
- **Byte-enable write and read-first.**
  - Write addr 3, data 0xFFFF_FFFF_FFFF_FFFF, `wr_be`=0x0F, while port0 reads addr 3 in the same cycle. The response is 3.
  - A read of addr 3 the next cycle returns 0x0000_0000_FFFF_FFFF.
- **Stall hold.**
  - Port0 is accepted on addr 7, then `stall`=1 for 3 cycles with valid kept high. Ready stays 0; `rd_resp_valid`=1 and data 7 are held; the counter is unchanged.
  - After release, the next request is accepted the same cycle.
- **Reset mid-flight and saturation.**
  - Accept a read, then assert `rst` at the next edge. The response outputs become 0.
  - With `CNT_WIDTH`=2, a sustained conflict saturates `conflict_count` at 3.
